midi_gate_ctrl: RTL and testbench

Monophonic MIDI note front-end that drives the envelope generator's gate input. Receives a raw 31250-baud MIDI serial stream, decodes Note-On/Note-Off messages for one channel, including running status, and produces a registered GATE level plus the current NOTE and VELOCITY. Sits directly upstream of the ADSR envelope stage; NOTE also feeds oscillator pitch lookup.

---
 rtl/midi_pkg.sv | 62 ++++++
 rtl/midi_gate_ctrl_if.sv | 26 ++
 rtl/midi_uart_rx.sv | 138 +++++++++++++
 rtl/midi_gate_ctrl.sv | 157 +++++++++++++++
 tb/tb_midi_gate_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/midi_pkg.sv
// midi_pkg: shared constants and types for the MIDI gate front-end.
//   - status-nibble constants for the channel-voice messages
//   - thresholds separating realtime and system bytes
//   - running-status kind, parser state and receiver state enums
//   - classify_status(): maps a channel status byte to its running-status kind
package midi_pkg;

  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [3:0] ST_POLY_AT  = 4'hA;
  localparam logic [3:0] ST_CTRL     = 4'hB;
  localparam logic [3:0] ST_PROG     = 4'hC;
  localparam logic [3:0] ST_CHAN_AT  = 4'hD;
  localparam logic [3:0] ST_PITCH    = 4'hE;

  // Bytes at or above REALTIME_MIN are realtime; [SYSTEM_MIN, REALTIME_MIN) are system.
  localparam logic [7:0] REALTIME_MIN = 8'hF8;
  localparam logic [7:0] SYSTEM_MIN   = 8'hF0;

  typedef enum logic [2:0] {
    RS_NONE     = 3'd0,
    RS_NOTE_ON  = 3'd1,
    RS_NOTE_OFF = 3'd2,
    RS_SKIP2    = 3'd3,
    RS_SKIP1    = 3'd4
  } rs_kind_t;

  typedef enum logic {
    PS_IDLE = 1'b0,
    PS_D2   = 1'b1
  } parse_state_t;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_t;

  // Note messages on our channel are tracked; every other two-data-byte
  // message is skipped in pairs so its data bytes are never mistaken for notes.
  function automatic rs_kind_t classify_status(input logic [7:0] status,
                                               input logic [3:0] channel);
    rs_kind_t kind;
    case (status[7:4])
      ST_NOTE_ON: begin
        if (status[3:0] == channel) kind = RS_NOTE_ON;
        else                        kind = RS_SKIP2;
      end
      ST_NOTE_OFF: begin
        if (status[3:0] == channel) kind = RS_NOTE_OFF;
        else                        kind = RS_SKIP2;
      end
      ST_POLY_AT, ST_CTRL, ST_PITCH: kind = RS_SKIP2;
      ST_PROG, ST_CHAN_AT:           kind = RS_SKIP1;
      default:                       kind = RS_NONE;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/midi_gate_ctrl_if.sv
// midi_gate_ctrl_if: groups the MIDI serial input and the note/gate outputs.
//   MIDI_RX    raw serial line (idle high)
//   GATE       note-held level for the envelope stage
//   NOTE       current note number
//   VELOCITY   velocity of the current note
//   NOTE_VALID one-cycle pulse when NOTE/VELOCITY load
//   FRAME_ERR  one-cycle pulse on a low stop bit
// master = the side driving the serial line; slave = midi_gate_ctrl.
interface midi_gate_ctrl_if;
  logic       MIDI_RX;
  logic       GATE;
  logic [6:0] NOTE;
  logic [6:0] VELOCITY;
  logic       NOTE_VALID;
  logic       FRAME_ERR;

  modport master (
    output MIDI_RX,
    input  GATE, NOTE, VELOCITY, NOTE_VALID, FRAME_ERR
  );

  modport slave (
    input  MIDI_RX,
    output GATE, NOTE, VELOCITY, NOTE_VALID, FRAME_ERR
  );
endinterface

// File: rtl/midi_uart_rx.sv
// midi_uart_rx: 8N1 serial byte receiver for the MIDI line.
//   CLK        system clock
//   RST        synchronous active-high reset; aborts any byte in progress
//   rx_async   asynchronous serial input, idle high
//   byte_data  last received byte (stable while byte_valid is high)
//   byte_valid one-cycle strobe, the cycle after a good stop-bit sample
//   frame_err  one-cycle pulse, the cycle after a low stop-bit sample
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 31_250
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       rx_async,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int BIT_CYCLES  = CLK_HZ / BAUD;
  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  localparam int CNT_W       = $clog2(BIT_CYCLES + 1);

  logic             sync1_r, sync2_r, prev_r;
  logic             rx_s, fall_s;
  rx_state_t        state_r, state_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic [2:0]       idx_r, idx_n;
  logic [7:0]       shift_r, shift_n;
  logic             strobe_r, strobe_n;
  logic             ferr_r, ferr_n;

  // Two-flop synchroniser plus one history flop for edge detection. Reset
  // to 0 so a line held low across reset cannot fake a start edge: the line
  // has to be seen high before the receiver arms.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= rx_async;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign rx_s   = sync2_r;
  assign fall_s = prev_r & ~sync2_r;

  // Receiver state, bit timer, shift register and strobe registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r  <= RX_IDLE;
      cnt_r    <= '0;
      idx_r    <= 3'd0;
      shift_r  <= 8'h00;
      strobe_r <= 1'b0;
      ferr_r   <= 1'b0;
    end else begin
      state_r  <= state_n;
      cnt_r    <= cnt_n;
      idx_r    <= idx_n;
      shift_r  <= shift_n;
      strobe_r <= strobe_n;
      ferr_r   <= ferr_n;
    end
  end

  // Next-state logic: half a bit after the start edge we re-check the line,
  // then every full bit period lands on the middle of the next bit.
  always_comb begin
    state_n  = state_r;
    cnt_n    = cnt_r;
    idx_n    = idx_r;
    shift_n  = shift_r;
    strobe_n = 1'b0;
    ferr_n   = 1'b0;
    case (state_r)
      RX_IDLE: begin
        cnt_n = '0;
        idx_n = 3'd0;
        if (fall_s) state_n = RX_START;
        else        state_n = RX_IDLE;
      end
      RX_START: begin
        if (cnt_r == CNT_W'(HALF_CYCLES - 1)) begin
          cnt_n = '0;
          if (!rx_s) state_n = RX_DATA;
          else       state_n = RX_IDLE;
        end else begin
          cnt_n = cnt_r + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_r == CNT_W'(BIT_CYCLES - 1)) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift_r[7:1]};
          if (idx_r == 3'd7) begin
            state_n = RX_STOP;
          end else begin
            idx_n = idx_r + 3'd1;
          end
        end else begin
          cnt_n = cnt_r + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_r == CNT_W'(BIT_CYCLES - 1)) begin
          cnt_n = '0;
          if (rx_s) begin
            strobe_n = 1'b1;
            state_n  = RX_IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = RX_WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt_r + CNT_W'(1);
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s) state_n = RX_IDLE;
        else      state_n = RX_WAIT_HIGH;
      end
      default: begin
        state_n = RX_IDLE;
      end
    endcase
  end

  assign byte_data  = shift_r;
  assign byte_valid = strobe_r;
  assign frame_err  = ferr_r;

endmodule

// File: rtl/midi_gate_ctrl.sv
// midi_gate_ctrl: monophonic MIDI Note-On/Note-Off front-end.
//   CLK  system clock
//   RST  synchronous active-high reset
//   bus  midi_gate_ctrl_if.slave: MIDI_RX in; GATE, NOTE, VELOCITY,
//        NOTE_VALID, FRAME_ERR out (all outputs registered)
// Parameters: CLK_HZ, BAUD, CHANNEL (0-15), RETRIGGER (1 = one-cycle gate
// drop on a new note while the gate is held, 0 = legato).
module midi_gate_ctrl
  import midi_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 31_250,
  parameter int CHANNEL   = 0,
  parameter bit RETRIGGER = 1'b1
) (
  input logic             CLK,
  input logic             RST,
  midi_gate_ctrl_if.slave bus
);

  logic [7:0]   byte_data_s;
  logic         byte_valid_s;
  logic         frame_err_s;

  parse_state_t ps_r, ps_n;
  rs_kind_t     rs_r, rs_n;
  logic [6:0]   d1_r, d1_n;
  logic         gate_r, gate_n;
  logic [6:0]   note_r, note_n;
  logic [6:0]   vel_r, vel_n;
  logic         nv_r, nv_n;
  logic         pend_r, pend_n;

  midi_uart_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx (
    .CLK        (CLK),
    .RST        (RST),
    .rx_async   (bus.MIDI_RX),
    .byte_data  (byte_data_s),
    .byte_valid (byte_valid_s),
    .frame_err  (frame_err_s)
  );

  // Parser state, running status and the registered note/gate outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ps_r   <= PS_IDLE;
      rs_r   <= RS_NONE;
      d1_r   <= 7'd0;
      gate_r <= 1'b0;
      note_r <= 7'd0;
      vel_r  <= 7'd0;
      nv_r   <= 1'b0;
      pend_r <= 1'b0;
    end else begin
      ps_r   <= ps_n;
      rs_r   <= rs_n;
      d1_r   <= d1_n;
      gate_r <= gate_n;
      note_r <= note_n;
      vel_r  <= vel_n;
      nv_r   <= nv_n;
      pend_r <= pend_n;
    end
  end

  // Byte classification, running-status parsing and note actions. pend_r
  // marks the cycle after a retrigger drop, when the gate comes back high.
  always_comb begin
    ps_n   = ps_r;
    rs_n   = rs_r;
    d1_n   = d1_r;
    gate_n = gate_r;
    note_n = note_r;
    vel_n  = vel_r;
    nv_n   = 1'b0;
    pend_n = 1'b0;

    if (pend_r) begin
      gate_n = 1'b1;
    end else begin
      gate_n = gate_r;
    end

    if (byte_valid_s) begin
      if (byte_data_s >= REALTIME_MIN) begin
        // Realtime bytes may appear anywhere and leave parsing untouched.
        ps_n = ps_r;
      end else if (byte_data_s >= SYSTEM_MIN) begin
        rs_n = RS_NONE;
        ps_n = PS_IDLE;
      end else if (byte_data_s[7]) begin
        rs_n = classify_status(byte_data_s, 4'(CHANNEL));
        ps_n = PS_IDLE;
      end else begin
        case (ps_r)
          PS_IDLE: begin
            case (rs_r)
              RS_NONE:  ps_n = PS_IDLE;
              RS_SKIP1: ps_n = PS_IDLE;
              default: begin
                d1_n = byte_data_s[6:0];
                ps_n = PS_D2;
              end
            endcase
          end
          PS_D2: begin
            ps_n = PS_IDLE;
            case (rs_r)
              RS_NOTE_ON: begin
                if (byte_data_s[6:0] != 7'd0) begin
                  note_n = d1_r;
                  vel_n  = byte_data_s[6:0];
                  nv_n   = 1'b1;
                  if (gate_r && RETRIGGER) begin
                    gate_n = 1'b0;
                    pend_n = 1'b1;
                  end else begin
                    gate_n = 1'b1;
                  end
                end else if (gate_r && (d1_r == note_r)) begin
                  gate_n = 1'b0;
                end else begin
                  gate_n = gate_r;
                end
              end
              RS_NOTE_OFF: begin
                if (gate_r && (d1_r == note_r)) begin
                  gate_n = 1'b0;
                end else begin
                  gate_n = gate_r;
                end
              end
              default: begin
                ps_n = PS_IDLE;
              end
            endcase
          end
          default: begin
            ps_n = PS_IDLE;
          end
        endcase
      end
    end else begin
      ps_n = ps_r;
    end
  end

  assign bus.GATE       = gate_r;
  assign bus.NOTE       = note_r;
  assign bus.VELOCITY   = vel_r;
  assign bus.NOTE_VALID = nv_r;
  assign bus.FRAME_ERR  = frame_err_s;

endmodule

// File: tb/tb_midi_gate_ctrl.sv
// Testbench for midi_gate_ctrl: two instances share one serial line
// (channel 0 with retrigger, channel 3 legato) and are compared against a
// byte-level reference model after every transmitted byte.
module tb_midi_gate_ctrl;

  localparam int CLK_HZ = 500_000;
  localparam int BAUD   = 31_250;
  localparam int BITC   = CLK_HZ / BAUD;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic line = 1'b1;

  always #5 clk = ~clk;

  midi_gate_ctrl_if if0 ();
  midi_gate_ctrl_if if1 ();
  assign if0.MIDI_RX = line;
  assign if1.MIDI_RX = line;

  midi_gate_ctrl #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CHANNEL(0), .RETRIGGER(1'b1))
    u_dut0 (.CLK(clk), .RST(rst), .bus(if0));
  midi_gate_ctrl #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CHANNEL(3), .RETRIGGER(1'b0))
    u_dut1 (.CLK(clk), .RST(rst), .bus(if1));

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Observed activity on the outputs, sampled on the falling edge.
  int nv_cnt[2]   = '{0, 0};
  int fe_cnt[2]   = '{0, 0};
  int rise_cnt[2] = '{0, 0};
  int low_run[2]  = '{0, 0};
  int last_low[2] = '{0, 0};

  always @(negedge clk) begin
    if (if0.NOTE_VALID) nv_cnt[0] <= nv_cnt[0] + 1;
    if (if1.NOTE_VALID) nv_cnt[1] <= nv_cnt[1] + 1;
    if (if0.FRAME_ERR)  fe_cnt[0] <= fe_cnt[0] + 1;
    if (if1.FRAME_ERR)  fe_cnt[1] <= fe_cnt[1] + 1;
    if (!if0.GATE) low_run[0] <= low_run[0] + 1;
    else if (low_run[0] != 0) begin
      last_low[0] <= low_run[0]; low_run[0] <= 0; rise_cnt[0] <= rise_cnt[0] + 1;
    end
    if (!if1.GATE) low_run[1] <= low_run[1] + 1;
    else if (low_run[1] != 0) begin
      last_low[1] <= low_run[1]; low_run[1] <= 0; rise_cnt[1] <= rise_cnt[1] + 1;
    end
  end

  // Reference model: message-level view of each instance.
  int chan[2]   = '{0, 3};
  int retrig[2] = '{1, 0};
  int m_rs[2], m_have[2], m_d1[2], m_gate[2], m_note[2], m_vel[2];
  int m_nv[2]   = '{0, 0};
  int m_fe[2]   = '{0, 0};
  int m_rise[2] = '{0, 0};
  bit m_short[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_rs[i] = 0; m_have[i] = 0; m_d1[i] = 0;
      m_gate[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_short[i] = 1'b0;
    end
  endtask

  task automatic model_byte(input int b);
    for (int i = 0; i < 2; i++) begin
      m_short[i] = 1'b0;
      if (b >= 'hF8) begin
        // realtime: nothing changes
      end else if (b >= 'hF0) begin
        m_rs[i] = 0; m_have[i] = 0;
      end else if (b >= 'h80) begin
        m_rs[i] = b; m_have[i] = 0;
      end else if (m_rs[i] == 0 || (m_rs[i] / 16) == 'hC || (m_rs[i] / 16) == 'hD) begin
        // no status, or a one-data-byte message: byte is consumed
      end else if (m_have[i] == 0) begin
        m_d1[i] = b; m_have[i] = 1;
      end else begin
        m_have[i] = 0;
        if (m_rs[i] == 'h90 + chan[i] && b != 0) begin
          if (m_gate[i] == 0) m_rise[i]++;
          else if (retrig[i] != 0) begin m_rise[i]++; m_short[i] = 1'b1; end
          m_gate[i] = 1; m_note[i] = m_d1[i]; m_vel[i] = b; m_nv[i]++;
        end else if (m_rs[i] == 'h80 + chan[i] || m_rs[i] == 'h90 + chan[i]) begin
          if (m_gate[i] == 1 && m_d1[i] == m_note[i]) m_gate[i] = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic g; logic [6:0] n, v;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin g = if0.GATE; n = if0.NOTE; v = if0.VELOCITY; end
      else        begin g = if1.GATE; n = if1.NOTE; v = if1.VELOCITY; end
      check_eq($sformatf("%s.gate%0d", tag, i), int'(g), m_gate[i]);
      check_eq($sformatf("%s.note%0d", tag, i), int'(n), m_note[i]);
      check_eq($sformatf("%s.vel%0d", tag, i), int'(v), m_vel[i]);
      check_eq($sformatf("%s.nv_cycles%0d", tag, i), nv_cnt[i], m_nv[i]);
      check_eq($sformatf("%s.frame_err%0d", tag, i), fe_cnt[i], m_fe[i]);
      check_eq($sformatf("%s.gate_rises%0d", tag, i), rise_cnt[i], m_rise[i]);
      if (m_short[i]) check_eq($sformatf("%s.retrig_low%0d", tag, i), last_low[i], 1);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop, input string tag);
    line = 1'b0;
    repeat (BITC) @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      line = b[k];
      repeat (BITC) @(posedge clk);
    end
    line = ~bad_stop;
    repeat (BITC) @(posedge clk);
    if (bad_stop) begin
      line = 1'b1;
      repeat (BITC) @(posedge clk);
      m_fe[0]++; m_fe[1]++;
      for (int i = 0; i < 2; i++) m_short[i] = 1'b0;
    end else begin
      model_byte(int'(b));
    end
    @(negedge clk); #1;
    check_all(tag);
  endtask

  task automatic send_seq(input logic [7:0] bytes[$], input string tag);
    foreach (bytes[j]) send_byte(bytes[j], 1'b0, $sformatf("%s[%0d]", tag, j));
  endtask

  function automatic logic [7:0] pick_ch();
    int r = $urandom_range(0, 99);
    if (r < 45)      return 8'h00;
    else if (r < 90) return 8'h03;
    else             return 8'($urandom_range(0, 15));
  endfunction

  function automatic logic [7:0] rand_byte();
    int r = $urandom_range(0, 99);
    logic [7:0] notes[4] = '{8'h3C, 8'h40, 8'h43, 8'h48};
    if (r < 12)      return 8'h90 | pick_ch();
    else if (r < 20) return 8'h80 | pick_ch();
    else if (r < 24) return 8'hA0 | (8'($urandom_range(0, 2)) == 8'd2 ? 8'h40 : 8'($urandom_range(0, 1)) << 4) | pick_ch();
    else if (r < 27) return 8'hC0 | (8'($urandom_range(0, 1)) << 4) | pick_ch();
    else if (r < 30) return 8'($urandom_range(8'hF8, 8'hFF));
    else if (r < 32) return 8'($urandom_range(8'hF0, 8'hF7));
    else if (r < 55) return notes[$urandom_range(0, 3)];
    else if (r < 62) return 8'h00;
    else             return 8'($urandom_range(0, 127));
  endfunction

  initial begin
    model_reset();
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    check_all("reset_hold");
    rst = 1'b0;
    repeat (3 * BITC) @(posedge clk);
    @(negedge clk); #1;
    check_all("reset_idle");

    send_seq('{8'h90, 8'h3C, 8'h64}, "note_on");
    send_seq('{8'h80, 8'h3C, 8'h40}, "note_off");
    send_seq('{8'h90, 8'h3C, 8'h64, 8'h3C, 8'h00, 8'h40, 8'h50}, "running");
    send_seq('{8'h90, 8'h3C, 8'h64, 8'h90, 8'h43, 8'h70}, "retrig");
    send_seq('{8'h80, 8'h3C, 8'h00}, "stale_off");
    send_seq('{8'h93, 8'h45, 8'h20, 8'h93, 8'h45, 8'h21}, "legato");
    send_seq('{8'h90, 8'h3C, 8'hF8, 8'h64}, "realtime");
    send_seq('{8'h91, 8'h3C, 8'h64}, "other_chan");
    send_byte(8'h90, 1'b0, "ferr[0]");
    send_byte(8'h3E, 1'b1, "ferr[1]");
    send_seq('{8'h90, 8'h3E, 8'h55}, "after_ferr");

    // Short low glitch on the line must not start a byte.
    line = 1'b0;
    repeat (3) @(posedge clk);
    line = 1'b1;
    repeat (3 * BITC) @(posedge clk);
    @(negedge clk); #1;
    check_all("glitch");

    // Reset in the middle of a byte while a note is held.
    send_seq('{8'h90, 8'h50, 8'h60}, "pre_rst");
    line = 1'b0;
    repeat (3 * BITC) @(posedge clk);
    rst  = 1'b1;
    line = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk); #1;
    check_all("mid_rst");
    rst = 1'b0;
    repeat (3 * BITC) @(posedge clk);
    send_byte(8'h45, 1'b0, "post_rst_data");

    // Randomized traffic, including back-to-back bytes and framing errors.
    for (int t = 0; t < 260; t++) begin
      send_byte(rand_byte(), ($urandom_range(0, 99) < 4), $sformatf("rnd%0d", t));
      repeat ($urandom_range(0, 2) * (BITC / 2)) @(posedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
